// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - Start/Busy/Done handshake and operand/result bundle for mult_div_unit.
// Optional MULTDIV_UNSIGNED_EN adds the is_unsigned request bit.
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef MULTDIV_UNSIGNED_EN
  logic             is_unsigned;
`endif
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

`ifdef MULTDIV_UNSIGNED_EN
  modport master (output start, op, a, b, is_unsigned, input busy, done, div_zero, hi, lo);
  modport slave  (input start, op, a, b, is_unsigned, output busy, done, div_zero, hi, lo);
`else
  modport master (output start, op, a, b, input busy, done, div_zero, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, div_zero, hi, lo);
`endif
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - Iterative signed multiply / restoring divide into Hi/Lo, one bit per cycle.
// Optional MULTDIV_UNSIGNED_EN enables multu/divu via the is_unsigned request bit.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  mult_div_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state, state_nx;

  logic [CW-1:0]    cnt;
  logic             op_r, sa, sb;
  logic [WIDTH:0]   opnd;
  logic [WIDTH-1:0] hi_w, lo_w;
  logic             busy_r, done_r, dz_r;
  logic [WIDTH-1:0] hi_r, lo_r;

  logic             uns;
`ifdef MULTDIV_UNSIGNED_EN
  assign uns = bus.is_unsigned;
`else
  assign uns = 1'b0;
`endif

  // Magnitudes carry one extra bit so that |-2^(WIDTH-1)| is exact.
  logic             sgn_a, sgn_b, b_zero;
  logic [WIDTH:0]   mag_a, mag_b;
  always_comb begin
    sgn_a  = ~uns & bus.a[WIDTH-1];
    sgn_b  = ~uns & bus.b[WIDTH-1];
    mag_a  = sgn_a ? (~{1'b1, bus.a} + 1'b1) : {1'b0, bus.a};
    mag_b  = sgn_b ? (~{1'b1, bus.b} + 1'b1) : {1'b0, bus.b};
    b_zero = (bus.b == '0);
  end

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_s;
  logic             ge;
  logic [WIDTH-1:0] rem_nx;
  logic [2*WIDTH-1:0] prod_fix;
  always_comb begin
    sum      = {1'b0, hi_w} + (lo_w[0] ? opnd : '0);
    rem_s    = {hi_w, lo_w[WIDTH-1]};
    ge       = (rem_s >= opnd);
    rem_nx   = ge ? WIDTH'(rem_s - opnd) : rem_s[WIDTH-1:0];
    prod_fix = (sa ^ sb) ? -{hi_w, lo_w} : {hi_w, lo_w};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.start) state_nx = (bus.op && b_zero) ? DONE : RUN;
      RUN:  if (cnt == CW'(1)) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: if (done_r) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      op_r   <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      opnd   <= '0;
      hi_w   <= '0;
      lo_w   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          op_r   <= bus.op;
          sa     <= sgn_a;
          sb     <= sgn_b;
          cnt    <= CW'(WIDTH);
          busy_r <= 1'b1;
          if (bus.op) begin
            // A zero divisor parks the raw dividend in hi_w for the Hi result.
            opnd <= mag_b;
            hi_w <= b_zero ? bus.a : '0;
            lo_w <= mag_a[WIDTH-1:0];
          end else begin
            opnd <= mag_a;
            hi_w <= '0;
            lo_w <= mag_b[WIDTH-1:0];
          end
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (op_r) begin
            hi_w <= rem_nx;
            lo_w <= {lo_w[WIDTH-2:0], ge};
          end else begin
            hi_w <= sum[WIDTH:1];
            lo_w <= {sum[0], lo_w[WIDTH-1:1]};
          end
        end
        FIX: begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
          if (op_r) begin
            lo_r <= (sa ^ sb) ? -lo_w : lo_w;
            hi_r <= sa ? -hi_w : hi_w;
          end else begin
            {hi_r, lo_r} <= prod_fix;
          end
        end
        DONE: begin
          // Entry without done set means the divide-by-zero shortcut.
          if (done_r) begin
            done_r <= 1'b0;
            dz_r   <= 1'b0;
          end else begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
            dz_r   <= 1'b1;
            hi_r   <= hi_w;
            lo_r   <= '1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.div_zero = dz_r;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;
endmodule
